uart_rx: RTL
============

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 The block SHALL have parameter OVS_DIV, default 326, meaning clk cycles per 16x-oversample tick (9600 baud at 50 MHz).
REQ-002 The block SHALL have parameter DBIT, default 8, meaning data bits per frame.
REQ-003 The block SHALL have parameter SB_TICK, default 16, meaning oversample ticks per stop bit.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock.
REQ-005 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port rx, input, 1 bit: asynchronous serial line, idle high.
REQ-007 The block SHALL have port rx_data, output, DBIT bits: received word.
REQ-008 The block SHALL have port rx_valid, output, 1 bit: rx_data holds an unconsumed word.
REQ-009 The block SHALL have port rx_ready, input, 1 bit: consumer accepts the word.
REQ-010 The block SHALL have port frame_err, output, 1 bit: one-cycle pulse when the stop bit is sampled low.
REQ-011 The block SHALL have port overrun_err, output, 1 bit: one-cycle pulse when a frame completes while rx_valid is high.

Function
REQ-012 rx SHALL pass through a 2-flop synchronizer reset to 1; all decisions use the synchronized value.
REQ-013 The tick counter SHALL run free from 0 to OVS_DIV-1, wrap to 0, and assert tick for one cycle at OVS_DIV-1.
REQ-014 FSM states SHALL be IDLE, START, DATA and STOP; only tick cycles advance the state counters.
REQ-015 In IDLE, a low synchronized rx SHALL move the FSM to START with the tick count cleared.
REQ-016 In START, on the 8th tick, a low rx SHALL move the FSM to DATA; a high rx SHALL return it to IDLE (glitch reject, no flags).
REQ-017 In DATA, a bit SHALL be sampled every 16 ticks and shifted in LSB-first; after DBIT bits the FSM SHALL move to STOP.
REQ-018 In STOP, rx SHALL be sampled after SB_TICK ticks; the FSM SHALL return to IDLE in that same cycle.
REQ-019 A high stop sample SHALL load rx_data and set rx_valid in the following cycle.
REQ-020 A low stop sample SHALL pulse frame_err and leave rx_data and rx_valid unchanged.
REQ-021 A cycle with rx_valid and rx_ready both high SHALL clear rx_valid in the next cycle.
REQ-022 A good frame completing while rx_valid is high SHALL overwrite rx_data, keep rx_valid high and pulse overrun_err, even if rx_ready is high in the same cycle.
REQ-023 rx_data SHALL remain stable while rx_valid is high, except as allowed by REQ-022.

Reset
REQ-024 While reset is low, the FSM SHALL be in IDLE and all counters and the shift register SHALL be 0.
REQ-025 While reset is low, rx_data SHALL be 0, rx_valid 0, frame_err 0 and overrun_err 0.
REQ-026 Reset asserted mid-frame SHALL discard the partial frame; the first falling edge after release starts a new frame.

Configuration
REQ-027 With macro UART_RX_PARITY_EN defined, a PARITY state SHALL sit between DATA and STOP and sample one bit after 16 ticks.
REQ-028 With UART_RX_PARITY_EN defined, the block SHALL add output parity_err, 1 bit, reset 0, pulsing in the stop-sample cycle when the data bits and parity bit have odd total ones.
REQ-029 With UART_RX_PARITY_EN defined, a frame with a parity error SHALL NOT load rx_data or set rx_valid.
REQ-030 Without UART_RX_PARITY_EN, the PARITY state and the parity_err port SHALL be absent.

Structure
REQ-031 Package uart_pkg SHALL hold the FSM state enum, the default OVS_DIV/DBIT/SB_TICK constants and the oversample factor 16.
REQ-032 The tick counter SHALL be sub-module uart_os_tick (parameters N, M; ports clk, reset, tick), reusable by the transmitter.

Verification
REQ-033 With OVS_DIV=4 (64 clk/bit), rx_ready=1, send 0xA5 with good stop -> rx_data=0xA5 and rx_valid=1 for one cycle, with no errors.
REQ-034 With rx_ready=0, send 0x3C then 0xC3 -> rx_data=0xC3, rx_valid stays 1 and overrun_err pulses once at the second stop sample.
REQ-035 Drive a 20-clk low glitch on idle rx -> FSM returns to IDLE and rx_valid, frame_err and overrun_err all stay 0.
REQ-036 Send 0x55 with stop bit 0 -> frame_err pulses once, rx_valid stays 0, and a following good 0x12 frame is received correctly.
REQ-037 Assert reset during data bit 4 of 0xFF, release it, then send 0x81 -> only 0x81 is received.
REQ-038 With UART_RX_PARITY_EN defined, send 0x07 with parity bit 0 -> parity_err pulses and rx_valid stays 0; with parity bit 1 -> rx_data=0x07.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, default frame timing and the 16x oversample factor.
// The PARITY state exists only when UART_RX_PARITY_EN is defined.
package uart_pkg;

  localparam int OVS_FACTOR      = 16;
  localparam int DEFAULT_OVS_DIV = 326;
  localparam int DEFAULT_DBIT    = 8;
  localparam int DEFAULT_SB_TICK = 16;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    STOP   = 3'd3
`ifdef UART_RX_PARITY_EN
    , PARITY = 3'd4
`endif
  } uart_state_e;

endpackage

// File: rtl/uart_os_tick.sv
// Free-running divider producing a one-cycle tick every N clocks.
// Shared by the UART receiver and transmitter as the oversample time base.
module uart_os_tick
  import uart_pkg::*;
#(
  parameter int N = DEFAULT_OVS_DIV,
  parameter int M = 9
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  logic [M-1:0] cnt_q, cnt_d;

  assign tick  = (cnt_q == M'(N - 1));
  assign cnt_d = tick ? '0 : cnt_q + M'(1);

  // NOTE: sequential state is written with <= only, so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_rx.sv
// 16x-oversampling UART receiver with valid/ready output, frame and overrun error pulses.
// Define UART_RX_PARITY_EN to add a parity bit after the data bits and the parity_err output.
module uart_rx
  import uart_pkg::*;
#(
  parameter int OVS_DIV = DEFAULT_OVS_DIV,
  parameter int DBIT    = DEFAULT_DBIT,
  parameter int SB_TICK = DEFAULT_SB_TICK
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            rx,
  output logic [DBIT-1:0] rx_data,
  output logic            rx_valid,
  input  logic            rx_ready,
  output logic            frame_err,
  output logic            overrun_err
`ifdef UART_RX_PARITY_EN
  , output logic          parity_err
`endif
);

  localparam int TICK_W = (OVS_DIV > 1) ? $clog2(OVS_DIV) : 1;
  localparam int S_MAX  = (SB_TICK > OVS_FACTOR) ? SB_TICK : OVS_FACTOR;
  localparam int S_W    = $clog2(S_MAX);
  localparam int N_W    = (DBIT > 1) ? $clog2(DBIT) : 1;

  logic            rx_meta_q, rx_sync_q;
  logic            tick;
  uart_state_e     state_q, state_d;
  logic [S_W-1:0]  s_q, s_d;
  logic [N_W-1:0]  n_q, n_d;
  logic [DBIT-1:0] b_q, b_d;
  logic            stop_sample, good_frame;
  logic [DBIT-1:0] rx_data_q;
  logic            rx_valid_q, frame_err_q, overrun_err_q;
`ifdef UART_RX_PARITY_EN
  logic            par_q, par_d, par_bad, parity_err_q;
`endif

  uart_os_tick #(.N(OVS_DIV), .M(TICK_W)) u_tick (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  // Synchronizer resets to the idle level so release never looks like a start bit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_sync_q <= rx_meta_q;
    end
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    s_d         = s_q;
    n_d         = n_q;
    b_d         = b_q;
    stop_sample = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d       = par_q;
`endif
    case (state_q)
      IDLE: if (!rx_sync_q) begin
        state_d = START;
        s_d     = '0;
      end
      START: if (tick) begin
        if (s_q == S_W'(OVS_FACTOR / 2 - 1)) begin
          s_d     = '0;
          n_d     = '0;
          state_d = rx_sync_q ? IDLE : DATA;
        end else s_d = s_q + S_W'(1);
      end
      DATA: if (tick) begin
        if (s_q == S_W'(OVS_FACTOR - 1)) begin
          s_d = '0;
          b_d = {rx_sync_q, b_q[DBIT-1:1]};
          if (n_q == N_W'(DBIT - 1)) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else n_d = n_q + N_W'(1);
        end else s_d = s_q + S_W'(1);
      end
`ifdef UART_RX_PARITY_EN
      PARITY: if (tick) begin
        if (s_q == S_W'(OVS_FACTOR - 1)) begin
          s_d     = '0;
          par_d   = rx_sync_q;
          state_d = STOP;
        end else s_d = s_q + S_W'(1);
      end
`endif
      STOP: if (tick) begin
        if (s_q == S_W'(SB_TICK - 1)) begin
          s_d         = '0;
          stop_sample = 1'b1;
          state_d     = IDLE;
        end else s_d = s_q + S_W'(1);
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef UART_RX_PARITY_EN
  assign par_bad    = ^{b_q, par_q};
  assign good_frame = stop_sample & rx_sync_q & ~par_bad;
`else
  assign good_frame = stop_sample & rx_sync_q;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      s_q           <= '0;
      n_q           <= '0;
      b_q           <= '0;
      rx_data_q     <= '0;
      rx_valid_q    <= 1'b0;
      frame_err_q   <= 1'b0;
      overrun_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q         <= 1'b0;
      parity_err_q  <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      s_q           <= s_d;
      n_q           <= n_d;
      b_q           <= b_d;
      if (good_frame) rx_data_q <= b_q;
      // A new good frame wins over a same-cycle consume: the word is fresh.
      rx_valid_q    <= good_frame | (rx_valid_q & ~rx_ready);
      frame_err_q   <= stop_sample & ~rx_sync_q;
      overrun_err_q <= good_frame & rx_valid_q;
`ifdef UART_RX_PARITY_EN
      par_q         <= par_d;
      parity_err_q  <= stop_sample & par_bad;
`endif
    end
  end

  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign frame_err   = frame_err_q;
  assign overrun_err = overrun_err_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err  = parity_err_q;
`endif

endmodule
